level_display_bcd: RTL



---
 rtl/level_display_bcd.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/level_display_bcd.sv
// level_display_bcd: serial binary-to-BCD converter (shift-and-add-3, one bit
// per clock) driving NUM_DIGITS active-low seven-segment displays, with
// leading-zero blanking, overflow dashes and a blink mode.
//
// Handshake: load is sampled only while idle (busy=0); a conversion then runs
// for WIDTH+1 cycles with busy=1, and done pulses for exactly one cycle in the
// final cycle, the same cycle in which hex_out first shows the new value.
// Loads presented while busy are ignored.
module level_display_bcd #(
    parameter int WIDTH         = 8,
    parameter int NUM_DIGITS    = 3,
    parameter int BLINK_DIV     = 25000000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WIDTH-1:0]        value,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // state is the observable FSM state for checkers and debug
    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]        bin_sr;
    logic [BCD_W-1:0]        bcd;
    logic                    carry;
    logic [CNT_W-1:0]        shift_cnt;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W-1:0]        bcd_next;
    logic                    carry_next;
    logic                    start;
    logic                    last_shift;

    logic [BCD_W-1:0]        disp_bcd;
    logic                    disp_ovf;

    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_hidden;

    logic [7*NUM_DIGITS-1:0] hex_shown;
    logic                    lead_zero;
    logic [3:0]              digit_k;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign start      = (state == IDLE) && load;
    assign last_shift = (state == SHIFT) && (shift_cnt == LAST_SHIFT);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) state_next = COMMIT;
            end
            COMMIT: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every digit >= 5, then the shift by one bit
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
        bcd_next   = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
        carry_next = carry | bcd_adj[BCD_W-1];
    end

    // Conversion datapath; the display registers take the result of the final
    // shift so the new digits are visible in the COMMIT cycle alongside done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_sr    <= '0;
            bcd       <= '0;
            carry     <= 1'b0;
            shift_cnt <= '0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
        end else begin
            if (start) begin
                bin_sr    <= value;
                bcd       <= '0;
                carry     <= 1'b0;
                shift_cnt <= '0;
            end else if (state == SHIFT) begin
                bin_sr    <= bin_sr << 1;
                bcd       <= bcd_next;
                carry     <= carry_next;
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
            if (last_shift) begin
                disp_bcd <= bcd_next;
                disp_ovf <= carry_next;
            end
        end
    end

    // Blink timer: phase flips every BLINK_DIV cycles while enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BLK_W'(1);
        end
    end

    // Segment decode from the top digit down, tracking whether all digits so
    // far are zero so leading zeros can be blanked (digit 0 always shown)
    always_comb begin
        hex_shown = '1;
        lead_zero = 1'b1;
        digit_k   = 4'd0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit_k   = disp_bcd[4*k +: 4];
            lead_zero = lead_zero & (digit_k == 4'd0);
            if (disp_ovf)
                hex_shown[7*k +: 7] = SEG_DASH;
            else if ((BLANK_LEADING != 0) && (k != 0) && lead_zero)
                hex_shown[7*k +: 7] = SEG_BLANK;
            else
                hex_shown[7*k +: 7] = seg7(digit_k);
        end
    end

    assign hex_out  = blink_hidden ? '1 : hex_shown;
    assign overflow = disp_ovf;

endmodule
